// File: rtl/axi_rd_data_router.sv
// axi_rd_data_router: read-data return stage of a 2-master / 2-slave AXI
// read interconnect. Each slave keeps a FIFO of the master IDs of its
// accepted bursts. R beats from a slave are steered, with zero latency, to the
// master at the head of that FIFO. A per-master lock holds the path from the
// first beat of a burst until its RLAST handshake.
// Optional feature: define AXI_RD_RR_ARB_EN for per-master round-robin between
// slaves. Left undefined, slave 0 always wins contention.
module axi_rd_data_router #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clkk,
    input  logic                  resett,
    input  logic                  ar_push_s0,
    input  logic                  ar_mid_s0,
    input  logic                  ar_push_s1,
    input  logic                  ar_mid_s1,
    output logic                  s0_full,
    output logic                  s1_full,
    input  logic                  S0_RVALID,
    input  logic                  S1_RVALID,
    input  logic [DATA_WIDTH-1:0] S0_RDATA,
    input  logic [DATA_WIDTH-1:0] S1_RDATA,
    input  logic [1:0]            S0_RRESP,
    input  logic [1:0]            S1_RRESP,
    input  logic                  S0_RLAST,
    input  logic                  S1_RLAST,
    output logic                  S0_RREADY,
    output logic                  S1_RREADY,
    output logic                  M0_RVALID,
    output logic                  M1_RVALID,
    output logic [DATA_WIDTH-1:0] M0_RDATA,
    output logic [DATA_WIDTH-1:0] M1_RDATA,
    output logic [1:0]            M0_RRESP,
    output logic [1:0]            M1_RRESP,
    output logic                  M0_RLAST,
    output logic                  M1_RLAST,
    input  logic                  M0_RREADY,
    input  logic                  M1_RREADY,
    output logic [1:0]            route_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_S0 = 2'd1,
        LOCK_S1 = 2'd2
    } lock_state_t;

    // Slave-side and master-side signals gathered into indexable form
    logic [1:0]            s_vld;
    logic [1:0]            s_last;
    logic [1:0]            s_rdy;
    logic [DATA_WIDTH-1:0] s_data [2];
    logic [1:0]            s_resp [2];
    logic [1:0]            ar_push;
    logic [1:0]            ar_mid;
    logic [1:0]            m_rdy;
    logic [1:0]            m_vld;
    logic [DATA_WIDTH-1:0] m_data [2];
    logic [1:0]            m_resp [2];
    logic [1:0]            m_last;

    // Ownership FIFO status per slave
    logic [1:0] full_q;
    logic [1:0] empty;
    logic [1:0] head;
    logic [1:0] pop;
    logic [1:0] push_ok;

    // req[s][m]: slave s has a beat for master m
    logic [1:0]  req [2];
    lock_state_t state [2];
    logic [1:0]  gnt_v;
    logic [1:0]  gnt_s;
    logic [1:0]  hs;
    logic [1:0]  beat_last;
    logic [1:0]  pref;

    assign s_vld     = {S1_RVALID, S0_RVALID};
    assign s_last    = {S1_RLAST, S0_RLAST};
    assign s_data[0] = S0_RDATA;
    assign s_data[1] = S1_RDATA;
    assign s_resp[0] = S0_RRESP;
    assign s_resp[1] = S1_RRESP;
    assign ar_push   = {ar_push_s1, ar_push_s0};
    assign ar_mid    = {ar_mid_s1, ar_mid_s0};
    assign m_rdy     = {M1_RREADY, M0_RREADY};

    assign S0_RREADY = s_rdy[0];
    assign S1_RREADY = s_rdy[1];
    assign M0_RVALID = m_vld[0];
    assign M1_RVALID = m_vld[1];
    assign M0_RDATA  = m_data[0];
    assign M1_RDATA  = m_data[1];
    assign M0_RRESP  = m_resp[0];
    assign M1_RRESP  = m_resp[1];
    assign M0_RLAST  = m_last[0];
    assign M1_RLAST  = m_last[1];
    assign s0_full   = full_q[0];
    assign s1_full   = full_q[1];

    for (genvar s = 0; s < 2; s++) begin : g_own
        logic [DEPTH-1:0] mem;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_nxt;
        logic             full_r;

        assign empty[s]   = (count == '0);
        assign head[s]    = mem[rd_ptr];
        assign full_q[s]  = full_r;
        // A pop on an empty FIFO is a sunk stray beat and must not move pointers
        assign pop[s]     = s_vld[s] & s_rdy[s] & s_last[s] & ~empty[s];
        // A pop in the same cycle frees the slot, so push is allowed even when full
        assign push_ok[s] = ar_push[s] & (~full_r | pop[s]);

        // Occupancy after this cycle's push/pop
        always_comb begin
            count_nxt = count;
            case ({push_ok[s], pop[s]})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end

        // Ownership FIFO storage, pointers and registered full flag
        always_ff @(posedge clkk) begin
            if (resett) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full_r <= 1'b0;
            end else begin
                if (push_ok[s]) begin
                    mem[wr_ptr] <= ar_mid[s];
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop[s]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count  <= count_nxt;
                full_r <= (count_nxt == CNT_W'(DEPTH));
            end
        end
    end

`ifdef AXI_RD_RR_ARB_EN
    logic [1:0] rr_ptr;

    assign pref = rr_ptr;

    // Round-robin preference: move away from a slave once its burst completes
    always_ff @(posedge clkk) begin
        if (resett) begin
            rr_ptr <= 2'b00;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (hs[m] && beat_last[m] && (gnt_s[m] == rr_ptr[m])) begin
                    rr_ptr[m] <= ~rr_ptr[m];
                end
            end
        end
    end
`else
    assign pref = 2'b00;
`endif

    // Slave requests: valid beat with a known owner; reset masks everything
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 2; m++) begin
                req[s][m] = ~resett & s_vld[s] & ~empty[s] & (head[s] == 1'(m));
            end
        end
    end

    // Per-master grant: lock state restricts the source, IDLE arbitrates
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            gnt_v[m] = 1'b0;
            gnt_s[m] = 1'b0;
            case (state[m])
                IDLE: begin
                    if (req[0][m] && req[1][m]) begin
                        gnt_v[m] = 1'b1;
                        gnt_s[m] = pref[m];
                    end else if (req[0][m]) begin
                        gnt_v[m] = 1'b1;
                        gnt_s[m] = 1'b0;
                    end else if (req[1][m]) begin
                        gnt_v[m] = 1'b1;
                        gnt_s[m] = 1'b1;
                    end
                end
                LOCK_S0: begin
                    gnt_v[m] = req[0][m];
                    gnt_s[m] = 1'b0;
                end
                LOCK_S1: begin
                    gnt_v[m] = req[1][m];
                    gnt_s[m] = 1'b1;
                end
                default: begin
                    gnt_v[m] = 1'b0;
                    gnt_s[m] = 1'b0;
                end
            endcase
        end
    end

    // Zero-latency R path muxing and ready return; orphan beats are sunk
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            m_vld[m]     = gnt_v[m];
            m_data[m]    = gnt_v[m] ? s_data[gnt_s[m]] : '0;
            m_resp[m]    = gnt_v[m] ? s_resp[gnt_s[m]] : 2'b00;
            m_last[m]    = gnt_v[m] & s_last[gnt_s[m]];
            hs[m]        = gnt_v[m] & m_rdy[m];
            beat_last[m] = gnt_v[m] & s_last[gnt_s[m]];
        end
        for (int s = 0; s < 2; s++) begin
            s_rdy[s] = ~resett & s_vld[s] & empty[s];
            for (int m = 0; m < 2; m++) begin
                if (gnt_v[m] && (gnt_s[m] == 1'(s))) begin
                    s_rdy[s] = m_rdy[m];
                end
            end
        end
    end

    // Protocol errors: dropped push on a full FIFO, or a beat with no owner
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            route_err[s] = ~resett &
                           ((ar_push[s] & full_q[s] & ~pop[s]) | (s_vld[s] & empty[s]));
        end
    end

    // Lock FSM per master; a stalled first beat also locks so the grant cannot move
    always_ff @(posedge clkk) begin
        if (resett) begin
            for (int m = 0; m < 2; m++) begin
                state[m] <= IDLE;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                case (state[m])
                    IDLE: begin
                        if (gnt_v[m] && !(hs[m] && beat_last[m])) begin
                            state[m] <= gnt_s[m] ? LOCK_S1 : LOCK_S0;
                        end
                    end
                    LOCK_S0, LOCK_S1: begin
                        if (hs[m] && beat_last[m]) begin
                            state[m] <= IDLE;
                        end
                    end
                    default: state[m] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_data_router.sv
// Testbench for axi_rd_data_router: slave beat queues drive the R channels,
// expected master beats are queued when the stimulus is loaded and compared
// as the DUT hands beats to each master.
module tb_axi_rd_data_router;

    logic        clkk;
    logic        resett;
    logic        ar_push_s0, ar_mid_s0, ar_push_s1, ar_mid_s1;
    logic        s0_full, s1_full;
    logic        S0_RVALID, S1_RVALID;
    logic [31:0] S0_RDATA, S1_RDATA;
    logic [1:0]  S0_RRESP, S1_RRESP;
    logic        S0_RLAST, S1_RLAST;
    logic        S0_RREADY, S1_RREADY;
    logic        M0_RVALID, M1_RVALID;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic [1:0]  M0_RRESP, M1_RRESP;
    logic        M0_RLAST, M1_RLAST;
    logic        M0_RREADY, M1_RREADY;
    logic [1:0]  route_err;

    int n_tests = 0;
    int n_fail  = 0;

    // beat = {data, resp, last}
    logic [34:0] s0_q [$];
    logic [34:0] s1_q [$];
    logic [34:0] m0_exp [$];
    logic [34:0] m1_exp [$];
    logic [34:0] e0, e1;
    bit          h0, h1;
    logic [4:0]  rdy_pat;
    logic [31:0] t3_dat [5];

    axi_rd_data_router #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clkk(clkk), .resett(resett),
        .ar_push_s0(ar_push_s0), .ar_mid_s0(ar_mid_s0),
        .ar_push_s1(ar_push_s1), .ar_mid_s1(ar_mid_s1),
        .s0_full(s0_full), .s1_full(s1_full),
        .S0_RVALID(S0_RVALID), .S1_RVALID(S1_RVALID),
        .S0_RDATA(S0_RDATA), .S1_RDATA(S1_RDATA),
        .S0_RRESP(S0_RRESP), .S1_RRESP(S1_RRESP),
        .S0_RLAST(S0_RLAST), .S1_RLAST(S1_RLAST),
        .S0_RREADY(S0_RREADY), .S1_RREADY(S1_RREADY),
        .M0_RVALID(M0_RVALID), .M1_RVALID(M1_RVALID),
        .M0_RDATA(M0_RDATA), .M1_RDATA(M1_RDATA),
        .M0_RRESP(M0_RRESP), .M1_RRESP(M1_RRESP),
        .M0_RLAST(M0_RLAST), .M1_RLAST(M1_RLAST),
        .M0_RREADY(M0_RREADY), .M1_RREADY(M1_RREADY),
        .route_err(route_err)
    );

    always #5 clkk = ~clkk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clkk);
        #1;
    endtask

    task automatic load(input int s, input int m, input logic [31:0] base, input int n,
                        input logic [1:0] resp, input bit fwd);
        logic [34:0] b;
        for (int i = 0; i < n; i++) begin
            b = {base + 32'(i), resp, (i == n - 1)};
            if (s == 0) s0_q.push_back(b); else s1_q.push_back(b);
            if (fwd) begin
                if (m == 0) m0_exp.push_back(b); else m1_exp.push_back(b);
            end
        end
    endtask

    task automatic ar(input int s, input bit mid);
        next_cycle();
        if (s == 0) begin ar_push_s0 = 1'b1; ar_mid_s0 = mid; end
        else        begin ar_push_s1 = 1'b1; ar_mid_s1 = mid; end
        next_cycle();
        ar_push_s0 = 1'b0;
        ar_push_s1 = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while ((s0_q.size() + s1_q.size() + m0_exp.size() + m1_exp.size()) != 0 && i < 200) begin
            @(posedge clkk);
            #3;
            i++;
        end
        check_eq(tag, 64'(s0_q.size() + s1_q.size() + m0_exp.size() + m1_exp.size()), 64'(0));
    endtask

    // Slave 0 model: advance to the next queued beat after each handshake
    always begin
        @(negedge clkk);
        h0 = S0_RVALID && S0_RREADY;
        @(posedge clkk);
        #1;
        if (h0 && s0_q.size() > 0) s0_q.delete(0);
        if (s0_q.size() > 0) begin
            {S0_RDATA, S0_RRESP, S0_RLAST} = s0_q[0];
            S0_RVALID = 1'b1;
        end else begin
            {S0_RDATA, S0_RRESP, S0_RLAST} = '0;
            S0_RVALID = 1'b0;
        end
    end

    // Slave 1 model
    always begin
        @(negedge clkk);
        h1 = S1_RVALID && S1_RREADY;
        @(posedge clkk);
        #1;
        if (h1 && s1_q.size() > 0) s1_q.delete(0);
        if (s1_q.size() > 0) begin
            {S1_RDATA, S1_RRESP, S1_RLAST} = s1_q[0];
            S1_RVALID = 1'b1;
        end else begin
            {S1_RDATA, S1_RRESP, S1_RLAST} = '0;
            S1_RVALID = 1'b0;
        end
    end

    // Master-side scoreboard: every handshake must match the next expected beat
    always @(negedge clkk) begin
        if (M0_RVALID && M0_RREADY) begin
            if (m0_exp.size() == 0) begin
                check_eq("m0_unexpected_beat", 64'({M0_RDATA, M0_RRESP, M0_RLAST}), 64'(0));
            end else begin
                e0 = m0_exp.pop_front();
                check_eq("m0_beat", 64'({M0_RDATA, M0_RRESP, M0_RLAST}), 64'(e0));
            end
        end
        if (M1_RVALID && M1_RREADY) begin
            if (m1_exp.size() == 0) begin
                check_eq("m1_unexpected_beat", 64'({M1_RDATA, M1_RRESP, M1_RLAST}), 64'(0));
            end else begin
                e1 = m1_exp.pop_front();
                check_eq("m1_beat", 64'({M1_RDATA, M1_RRESP, M1_RLAST}), 64'(e1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        clkk = 1'b0;
        resett = 1'b1;
        ar_push_s0 = 1'b0; ar_mid_s0 = 1'b0; ar_push_s1 = 1'b0; ar_mid_s1 = 1'b0;
        S0_RVALID = 1'b0; S0_RDATA = '0; S0_RRESP = '0; S0_RLAST = 1'b0;
        S1_RVALID = 1'b0; S1_RDATA = '0; S1_RRESP = '0; S1_RLAST = 1'b0;
        M0_RREADY = 1'b1; M1_RREADY = 1'b1;
        rdy_pat = 5'b10101;
        t3_dat[0] = 32'hD0; t3_dat[1] = 32'hD1; t3_dat[2] = 32'hD1;
        t3_dat[3] = 32'hD2; t3_dat[4] = 32'hD2;

        // Reset state
        repeat (2) @(posedge clkk);
        #3;
        check_eq("rst_hold", 64'({M0_RVALID, M1_RVALID, S0_RREADY, S1_RREADY, route_err, s0_full, s1_full}), 64'(0));
        next_cycle();
        resett = 1'b0;
        #2;
        check_eq("rst_release", 64'({M0_RVALID, M1_RVALID, S0_RREADY, S1_RREADY, route_err, s0_full, s1_full}), 64'(0));

        // 4-beat S0 burst owned by M1
        ar(0, 1'b1);
        #2;
        load(0, 1, 32'hA0, 4, 2'b01, 1'b1);
        next_cycle();
        #2;
        check_eq("t1_same_cycle", 64'({M1_RVALID, M1_RDATA, M0_RVALID}), 64'({1'b1, 32'hA0, 1'b0}));
        wait_idle("t1_drain");

        // Orphan beat on S0 (its FIFO is empty after the burst above)
        load(0, 0, 32'h55, 1, 2'b00, 1'b0);
        next_cycle();
        #2;
        check_eq("t5_sink", 64'({S0_RREADY, route_err, M0_RVALID, M1_RVALID}), 64'({1'b1, 2'b01, 1'b0, 1'b0}));
        wait_idle("t5_drain");
        next_cycle();
        #2;
        check_eq("t5_err_clear", 64'(route_err), 64'(0));

        // Both slaves return 2-beat bursts for M0 together: S0 first, no interleave
        next_cycle();
        ar_push_s0 = 1'b1; ar_mid_s0 = 1'b0; ar_push_s1 = 1'b1; ar_mid_s1 = 1'b0;
        next_cycle();
        ar_push_s0 = 1'b0; ar_push_s1 = 1'b0;
        #2;
        load(0, 0, 32'hB0, 2, 2'b00, 1'b1);
        load(1, 0, 32'hC0, 2, 2'b10, 1'b1);
        next_cycle();
        #2;
        check_eq("t2_beat0", 64'({S0_RREADY, S1_RREADY, M0_RDATA}), 64'({1'b1, 1'b0, 32'hB0}));
        next_cycle();
        #2;
        check_eq("t2_beat1", 64'({S1_RREADY, M0_RDATA, M0_RLAST}), 64'({1'b0, 32'hB1, 1'b1}));
        next_cycle();
        #2;
        check_eq("t2_s1_start", 64'({S1_RREADY, M0_RDATA, M0_RRESP}), 64'({1'b1, 32'hC0, 2'b10}));
        wait_idle("t2_drain");

        // M1 back-pressure during a 3-beat S1 burst
        ar(1, 1'b1);
        #2;
        load(1, 1, 32'hD0, 3, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            M1_RREADY = rdy_pat[i];
            #2;
            check_eq("t3_mirror", 64'({S1_RREADY, M1_RVALID, M1_RDATA}), 64'({rdy_pat[i], 1'b1, t3_dat[i]}));
        end
        M1_RREADY = 1'b1;
        wait_idle("t3_drain");

        // Fill S1 ownership FIFO, overflow push, then drain
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            ar_push_s1 = 1'b1; ar_mid_s1 = 1'b0;
            #2;
            check_eq("t4_fill", 64'(s1_full), 64'(0));
        end
        next_cycle();
        #2;
        check_eq("t4_full_err", 64'({s1_full, route_err}), 64'({1'b1, 2'b10}));
        next_cycle();
        ar_push_s1 = 1'b0;
        #2;
        check_eq("t4_held", 64'({s1_full, route_err}), 64'({1'b1, 2'b00}));
        for (int k = 0; k < 4; k++) load(1, 0, 32'hE0 + 32'(k), 1, 2'b00, 1'b1);
        next_cycle();
        #2;
        check_eq("t4_first", 64'({s1_full, M0_RDATA, M0_RLAST}), 64'({1'b1, 32'hE0, 1'b1}));
        next_cycle();
        #2;
        check_eq("t4_pop", 64'(s1_full), 64'(0));
        wait_idle("t4_drain");

        // Reset in the middle of a 4-beat burst
        ar(0, 1'b0);
        #2;
        load(0, 0, 32'hF0, 4, 2'b00, 1'b1);
        next_cycle();
        #2;
        check_eq("t6_beat0", 64'(M0_RDATA), 64'(32'hF0));
        next_cycle();
        #2;
        check_eq("t6_beat1", 64'(M0_RDATA), 64'(32'hF1));
        resett = 1'b1;
        s0_q.delete();
        m0_exp.delete();
        next_cycle();
        #2;
        check_eq("t6_rst_outs", 64'({M0_RVALID, M1_RVALID, S0_RREADY, S1_RREADY, route_err, s0_full, s1_full,
                                     M0_RDATA, M0_RRESP, M0_RLAST}), 64'(0));
        resett = 1'b0;
        load(0, 0, 32'h66, 1, 2'b00, 1'b0);
        next_cycle();
        #2;
        check_eq("t6_fifo_empty", 64'({S0_RREADY, route_err, M0_RVALID}), 64'({1'b1, 2'b01, 1'b0}));
        wait_idle("t6_sink_drain");
        ar(1, 1'b0);
        #2;
        load(1, 0, 32'hC5, 1, 2'b00, 1'b1);
        next_cycle();
        #2;
        check_eq("t6_fsm_idle", 64'({M0_RVALID, M0_RDATA}), 64'({1'b1, 32'hC5}));
        wait_idle("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_data_router.md
# axi_rd_data_router

Read-data return stage of the 2-master/2-slave AXI read interconnect, directly downstream of the address-phase controller. Records which master owns each accepted read burst on each slave, then steers the slave R-channel beats (data, resp, last) back to the owning master. Arbitrates when both slaves return data for the same master and holds the path for a whole burst until RLAST.

## Interface
Parameters:
- DATA_WIDTH, 32, RDATA width
- DEPTH, 4, outstanding bursts tracked per slave (power of 2, ≥2)

Ports:
- clkk  in  1  clock, all logic on rising edge
- resett  in  1  reset, synchronous, active-high
- ar_push_s0  in  1  AR handshake to slave 0 completed this cycle
- ar_mid_s0  in  1  issuing master of that burst (0=M0, 1=M1)
- ar_push_s1  in  1  AR handshake to slave 1 completed this cycle
- ar_mid_s1  in  1  issuing master of that burst
- s0_full, s1_full  out  1  ownership queue full; the address stage must not accept AR to that slave
- S0_RVALID, S1_RVALID  in  1  slave read valid
- S0_RDATA, S1_RDATA  in  DATA_WIDTH  slave read data
- S0_RRESP, S1_RRESP  in  2  slave read response
- S0_RLAST, S1_RLAST  in  1  slave last beat
- S0_RREADY, S1_RREADY  out  1  ready to slave
- M0_RVALID, M1_RVALID  out  1  valid to master
- M0_RDATA, M1_RDATA  out  DATA_WIDTH  data to master
- M0_RRESP, M1_RRESP  out  2  response to master
- M0_RLAST, M1_RLAST  out  1  last to master
- M0_RREADY, M1_RREADY  in  1  master ready
- route_err  out  2  bit s: one-cycle pulse on slave-s protocol error

## Operation
- Per slave: ownership FIFO of DEPTH 1-bit master IDs. Push ar_mid_s on ar_push_s; pop on RLAST handshake (S_RVALID & S_RREADY & S_RLAST). Push and pop in same cycle legal, including when full (count unchanged).
- Slave s requests master head(s) when S_RVALID=1 and FIFO s non-empty.
- Per master: lock FSM IDLE / LOCK_S0 / LOCK_S1.
  - IDLE: grant to the requesting slave; if both request, pick by arbitration policy (Configuration). On a granted beat handshake with RLAST=0 -> LOCK_Sx; with RLAST=1 stay IDLE.
  - LOCK_Sx: only slave x routed, other slave's request stalls; on RLAST handshake -> IDLE.
- Routing, combinational: M_RVALID/RDATA/RRESP/RLAST = granted slave's signals; granted S_RREADY = M_RREADY; non-granted S_RREADY = 0. No grant: M_RVALID=0, RDATA/RRESP/RLAST=0.
- Push while full: push dropped, route_err[s] pulses.
- S_RVALID=1 with FIFO s empty: beat sunk (S_RREADY=1), not forwarded, route_err[s] pulses each such cycle.
- s_full = (count == DEPTH), registered.

## Timing
- R path zero latency: slave beat visible at master in same cycle; no beat buffering.
- Ownership pushed at cycle N is usable for routing at cycle N+1.
- Grant/lock changes take effect the cycle after the completing handshake.
- A master's RVALID, once asserted with a grant, stays with the same slave until handshake (no regrant in IDLE while granted slave holds RVALID).
- Reset (any cycle, including mid-burst): FIFOs empty, counts 0, all FSMs IDLE, RR pointers prefer S0, s*_full=0, route_err=0, all M_RVALID/S_RREADY=0. In-flight bursts are discarded.

## Configuration
- AXI_RD_RR_ARB_EN defined: per-master round-robin; pointer flips to the other slave after each completed burst from the preferred slave, initial preference S0.
- Undefined: fixed priority, S0 always wins IDLE contention; no pointer state.

## Test plan
- Push s0 mid=1, S0 returns 4-beat burst 0xA0..0xA3 with M1_RREADY=1 -> M1 gets 4 beats same cycle, RLAST on 4th, M0_RVALID stays 0, s0 FIFO empty after.
- Push s0 mid=0 and s1 mid=0 same cycle; both slaves return 2-beat bursts together -> with macro: S0 burst then S1 burst, no interleave; without macro: S0 first; S1_RREADY=0 during S0 burst.
- M1_RREADY toggles 1,0,1,0 during 3-beat S1 burst -> S1_RREADY mirrors M1_RREADY, data held, 3 beats delivered in order.
- DEPTH=4: 4 pushes to s1 -> s1_full=1 next cycle; 5th push -> route_err[1] pulse, count stays 4; RLAST pop -> s1_full=0.
- S0_RVALID=1 with empty s0 FIFO -> S0_RREADY=1, route_err[0]=1, no M*_RVALID.
- resett asserted mid-burst (beat 2 of 4) -> next cycle all outputs 0, FIFOs empty, FSMs IDLE.
